// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage and the main decoder:
//   - fetch_state_t : fetch controller state encoding (BOOT / RUN)
//   - OP_*          : recognised major opcodes
//   - NOP           : canonical no-operation word (addi x0, x0, 0)
//   - op_is_legal() : opcode classification shared with the decoder
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    localparam logic [6:0]  OP_LW    = 7'b0000011;
    localparam logic [6:0]  OP_SW    = 7'b0100011;
    localparam logic [6:0]  OP_RTYPE = 7'b0110011;
    localparam logic [6:0]  OP_BEQ   = 7'b1100011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // True when the opcode is one the decoder implements.
    function automatic logic op_is_legal(input logic [6:0] opcode);
        logic legal;
        case (opcode)
            OP_LW:    legal = 1'b1;
            OP_SW:    legal = 1'b1;
            OP_RTYPE: legal = 1'b1;
            OP_BEQ:   legal = 1'b1;
            default:  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with asynchronous active-low reset and load enable.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, loads RESET_PC
//   i_load    in   1 = capture i_next_pc on this edge
//   i_next_pc in   next PC value (selected by fetch_stage)
//   o_pc      out  current PC (registered)
// -----------------------------------------------------------------------------
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_next_pc,
    output logic [31:0] o_pc
);

    // The PC is always word aligned, even if RESET_PC is misconfigured.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] r_pc;

    // PC register: reset to RESET_PC, otherwise load when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC_ALIGNED;
        end else if (i_load) begin
            r_pc <= i_next_pc;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule : pc_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Single-issue instruction fetch stage: PC, next-PC selection, BOOT/RUN
// controller and the IF/ID pipeline register.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pc_src       in   redirect request (1 = take pc_target)
//   pc_target    in   redirect address (low two bits ignored)
//   id_ready     in   decode can accept IF/ID this cycle
//   imem_addr    out  instruction memory address (= current PC)
//   imem_rdata   in   instruction word for imem_addr (combinational)
//   if_valid     out  IF/ID holds a live instruction
//   if_instr     out  registered instruction word
//   if_pc        out  PC of if_instr
//   if_pc_plus4  out  if_pc + 4
//   op           out  if_instr[6:0], feeds the main decoder
//   if_illegal   out  live instruction with an unimplemented opcode
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        id_ready,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [6:0]  op,
    output logic        if_illegal
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_pc_load;
    logic        w_ifid_load;
    logic        w_ifid_kill;
    logic        w_adv;

    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;

    // Redirect targets are forced word aligned; the dropped bits are unused.
    logic        w_unused_target_lsbs;
    assign w_unused_target_lsbs = ^pc_target[1:0];

    // Natural 32-bit add: wraps from FFFF_FFFC to 0000_0000 silently.
    assign w_pc_plus4 = w_pc + 32'd4;

    // An empty IF/ID slot can always be refilled.
    assign w_adv = (!r_if_valid) | id_ready;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_pc_load),
        .i_next_pc (w_pc_next),
        .o_pc      (w_pc)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Controller next state: BOOT lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_BOOT;
        endcase
    end

    // Controller outputs: redirect beats stall, stall beats advance.
    always_comb begin
        w_pc_load   = 1'b0;
        w_pc_next   = w_pc;
        w_ifid_load = 1'b0;
        w_ifid_kill = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_pc_load   = 1'b0;
                w_ifid_kill = 1'b1;
            end
            ST_RUN: begin
                if (pc_src) begin
                    // Squash the wrong-path word currently on imem_rdata.
                    w_pc_load   = 1'b1;
                    w_pc_next   = {pc_target[31:2], 2'b00};
                    w_ifid_kill = 1'b1;
                end else if (w_adv) begin
                    w_pc_load   = 1'b1;
                    w_pc_next   = w_pc_plus4;
                    w_ifid_load = 1'b1;
                end else begin
                    w_pc_load   = 1'b0;
                    w_ifid_load = 1'b0;
                end
            end
            default: begin
                w_pc_load   = 1'b0;
                w_ifid_kill = 1'b1;
            end
        endcase
    end

    // IF/ID pipeline register; a kill only clears the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid    <= 1'b0;
            r_if_instr    <= NOP;
            r_if_pc       <= 32'h0000_0000;
            r_if_pc_plus4 <= 32'h0000_0000;
        end else if (w_ifid_kill) begin
            r_if_valid    <= 1'b0;
        end else if (w_ifid_load) begin
            r_if_valid    <= 1'b1;
            r_if_instr    <= imem_rdata;
            r_if_pc       <= w_pc;
            r_if_pc_plus4 <= w_pc_plus4;
        end else begin
            r_if_valid    <= r_if_valid;
        end
    end

    assign imem_addr   = w_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;

    // Decode-facing views come straight from IF/ID so they are glitch-free
    // with respect to imem_rdata.
    assign op         = r_if_instr[6:0];
    assign if_illegal = r_if_valid & ~op_is_legal(r_if_instr[6:0]);

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage: reset/boot, stall, redirect, PC wrap,
// illegal-opcode flag and asynchronous reset during a stall.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        id_ready;
    logic [31:0] imem_rdata;

    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [6:0]  op;
    logic        if_illegal;

    logic [31:0] w2_imem_addr;
    logic        w2_if_valid;
    logic [31:0] w2_if_instr;
    logic [31:0] w2_if_pc;
    logic [31:0] w2_if_pc_plus4;
    logic [6:0]  w2_op;
    logic        w2_if_illegal;

    int checks;
    int failures;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .id_ready    (id_ready),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .op          (op),
        .if_illegal  (if_illegal)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .id_ready    (id_ready),
        .imem_addr   (w2_imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (w2_if_valid),
        .if_instr    (w2_if_instr),
        .if_pc       (w2_if_pc),
        .if_pc_plus4 (w2_if_pc_plus4),
        .op          (w2_op),
        .if_illegal  (w2_if_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, release just after an edge.
    task automatic do_reset(input logic [31:0] word);
        rst_n      = 1'b0;
        pc_src     = 1'b0;
        pc_target  = 32'h0;
        id_ready   = 1'b1;
        imem_rdata = word;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(32'h0000_0033);
        // still in BOOT before the first edge with rst_n=1
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", if_instr); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
        checks++; if (if_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=0", if_pc_plus4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        step(); // BOOT edge: bubble
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", if_valid); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL boot_addr got=%h exp=0", imem_addr); end
        step();
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL run_valid got=%b exp=1", if_valid); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL run_pc0 got=%h exp=0", if_pc); end
        checks++; if (if_pc_plus4 !== 32'h4) begin failures++; $display("FAIL run_pc4 got=%h exp=4", if_pc_plus4); end
        checks++; if (if_instr !== 32'h0000_0033) begin failures++; $display("FAIL run_instr got=%h exp=00000033", if_instr); end
        checks++; if (op !== 7'h33 || if_illegal !== 1'b0) begin failures++; $display("FAIL run_op got=%h/%b exp=33/0", op, if_illegal); end
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL run_addr got=%h exp=4", imem_addr); end
        step();
        checks++; if (if_pc !== 32'h4) begin failures++; $display("FAIL run_pc1 got=%h exp=4", if_pc); end
        step();
        checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL run_pc2 got=%h exp=8", if_pc); end
        checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL run_addr2 got=%h exp=c", imem_addr); end
    endtask

    // Continues from test_reset: if_pc=8, imem_addr=12.
    task automatic test_stall();
        id_ready   = 1'b0;
        imem_rdata = 32'h0000_0003;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=8", i, if_pc); end
            checks++; if (if_instr !== 32'h0000_0033) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=00000033", i, if_instr); end
            checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=c", i, imem_addr); end
            checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, if_valid); end
        end
        id_ready = 1'b1;
        step();
        checks++; if (if_pc !== 32'hC) begin failures++; $display("FAIL unstall_pc got=%h exp=c", if_pc); end
        checks++; if (if_instr !== 32'h0000_0003) begin failures++; $display("FAIL unstall_instr got=%h exp=00000003", if_instr); end
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL unstall_addr got=%h exp=10", imem_addr); end
    endtask

    // Continues with a live instruction in IF/ID; redirect while stalled.
    task automatic test_redirect();
        id_ready   = 1'b0;
        pc_src     = 1'b1;
        pc_target  = 32'h0000_0103;
        imem_rdata = 32'h0000_0006; // wrong-path, illegal word must not show
        step();
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", if_valid); end
        checks++; if (if_illegal !== 1'b0) begin failures++; $display("FAIL redir_illegal got=%b exp=0", if_illegal); end
        pc_src     = 1'b0;
        imem_rdata = 32'h0000_0023;
        step();
        checks++; if (if_pc !== 32'h100) begin failures++; $display("FAIL redir_pc got=%h exp=100", if_pc); end
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL redir_valid2 got=%b exp=1", if_valid); end
        checks++; if (if_pc_plus4 !== 32'h104) begin failures++; $display("FAIL redir_pc4 got=%h exp=104", if_pc_plus4); end
        checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL redir_addr2 got=%h exp=104", imem_addr); end
        checks++; if (if_instr !== 32'h0000_0023) begin failures++; $display("FAIL redir_instr got=%h exp=00000023", if_instr); end
        id_ready = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset(32'h0000_0033);
        checks++; if (w2_imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_rst_addr got=%h exp=fffffff8", w2_imem_addr); end
        step();
        checks++; if (w2_if_valid !== 1'b0) begin failures++; $display("FAIL wrap_boot got=%b exp=0", w2_if_valid); end
        step();
        checks++; if (w2_if_pc !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", w2_if_pc); end
        step();
        checks++; if (w2_if_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", w2_if_pc); end
        checks++; if (w2_if_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", w2_if_pc_plus4); end
        step();
        checks++; if (w2_if_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc2 got=%h exp=0", w2_if_pc); end
        checks++; if (w2_if_pc_plus4 !== 32'h4) begin failures++; $display("FAIL wrap_pc2_4 got=%h exp=4", w2_if_pc_plus4); end
    endtask

    task automatic test_illegal();
        do_reset(32'h0000_0006);
        step(); // BOOT bubble with illegal word on the bus
        checks++; if (if_illegal !== 1'b0) begin failures++; $display("FAIL ill_boot got=%b exp=0", if_illegal); end
        step();
        checks++; if (op !== 7'h06) begin failures++; $display("FAIL ill_op got=%h exp=06", op); end
        checks++; if (if_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", if_illegal); end
        imem_rdata = 32'h0000_0003;
        step();
        checks++; if (op !== 7'h03 || if_illegal !== 1'b0) begin failures++; $display("FAIL ill_lw got=%h/%b exp=03/0", op, if_illegal); end
        imem_rdata = 32'h0000_0063;
        step();
        checks++; if (op !== 7'h63 || if_illegal !== 1'b0) begin failures++; $display("FAIL ill_beq got=%h/%b exp=63/0", op, if_illegal); end
        imem_rdata = 32'h0000_0013; // addi: not in the implemented set
        step();
        checks++; if (if_illegal !== 1'b1) begin failures++; $display("FAIL ill_addi got=%b exp=1", if_illegal); end
    endtask

    task automatic test_async_reset();
        do_reset(32'h0000_0033);
        step();
        step();
        step(); // if_pc=4, imem_addr=8
        id_ready = 1'b0;
        step(); // stalled
        #3;
        rst_n = 1'b0;
        #1; // well before the next rising edge
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0000_0013) begin failures++; $display("FAIL arst_instr got=%h exp=00000013", if_instr); end
        checks++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin failures++; $display("FAIL arst_pc got=%h/%h exp=0/0", if_pc, if_pc_plus4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL arst_addr got=%h exp=0", imem_addr); end
        step();
        rst_n = 1'b1;
        id_ready = 1'b1;
        step(); // BOOT again: nothing survives
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL arst_boot got=%b exp=0", if_valid); end
        step();
        checks++; if (if_pc !== 32'h0 || if_valid !== 1'b1) begin failures++; $display("FAIL arst_restart got=%h/%b exp=0/1", if_pc, if_valid); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        pc_src     = 1'b0;
        pc_target  = 32'h0;
        id_ready   = 1'b1;
        imem_rdata = 32'h0000_0033;
        test_reset();
        test_stall();
        test_redirect();
        test_wrap();
        test_illegal();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
